// File: rtl/axi_lite_csr_bridge.sv
// axi_lite_csr_bridge
// AXI4-Lite slave in front of the I3CCSR passthrough CPU interface. AW, W and AR each
// land in a one-entry holding register, a small FSM arbitrates fairly between reads and
// writes, decodes the address window and issues one CSR request at a time.
// Optional feature macro: I3C_AXI_LITE_TIMEOUT_EN bounds the WAIT_ACK dwell by
// TimeoutCycles and answers SLVERR when it expires; without it WAIT_ACK waits forever.

`ifndef I3CCSR_MIN_ADDR_WIDTH
`define I3CCSR_MIN_ADDR_WIDTH 12
`endif

module axi_lite_csr_bridge #(
   parameter int unsigned             AxiAddrWidth  = 32,
   parameter int unsigned             CsrAddrWidth  = `I3CCSR_MIN_ADDR_WIDTH,
   parameter logic [AxiAddrWidth-1:0] BaseAddr      = '0,
   parameter longint unsigned         WindowBytes   = 64'd1 << CsrAddrWidth,
   parameter int unsigned             TimeoutCycles = 256
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   // write address channel
   input  logic                    awvalid_i,
   output logic                    awready_o,
   input  logic [AxiAddrWidth-1:0] awaddr_i,
   input  logic [2:0]              awprot_i,
   // write data channel
   input  logic                    wvalid_i,
   output logic                    wready_o,
   input  logic [31:0]             wdata_i,
   input  logic [3:0]              wstrb_i,
   // write response channel
   output logic                    bvalid_o,
   input  logic                    bready_i,
   output logic [1:0]              bresp_o,
   // read address channel
   input  logic                    arvalid_i,
   output logic                    arready_o,
   input  logic [AxiAddrWidth-1:0] araddr_i,
   input  logic [2:0]              arprot_i,
   // read data channel
   output logic                    rvalid_o,
   input  logic                    rready_i,
   output logic [31:0]             rdata_o,
   output logic [1:0]              rresp_o,
   // CSR passthrough interface
   output logic                    s_cpuif_req,
   output logic                    s_cpuif_req_is_wr,
   output logic [CsrAddrWidth-1:0] s_cpuif_addr,
   output logic [31:0]             s_cpuif_wr_data,
   output logic [31:0]             s_cpuif_wr_biten,
   input  logic                    s_cpuif_req_stall_wr,
   input  logic                    s_cpuif_req_stall_rd,
   input  logic                    s_cpuif_rd_ack,
   input  logic                    s_cpuif_rd_err,
   input  logic [31:0]             s_cpuif_rd_data,
   input  logic                    s_cpuif_wr_ack,
   input  logic                    s_cpuif_wr_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, RESP} state_e;

   localparam logic [AxiAddrWidth:0] WinSize = (AxiAddrWidth+1)'(WindowBytes);

   // An address below BaseAddr borrows into the extra MSB, so one compare covers both bounds.
   function automatic logic in_window(input logic [AxiAddrWidth-1:0] addr);
      logic [AxiAddrWidth:0] diff;
      diff = {1'b0, addr} - {1'b0, BaseAddr};
      return diff < WinSize;
   endfunction

   function automatic logic [CsrAddrWidth-1:0] window_offset(input logic [AxiAddrWidth-1:0] addr);
      logic [CsrAddrWidth-1:0] off;
      off = CsrAddrWidth'(addr - BaseAddr);
      return off & ~(CsrAddrWidth'(2'b11));
   endfunction

   function automatic logic [31:0] expand_strb(input logic [3:0] strb);
      logic [31:0] mask;
      for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{strb[i]}};
      return mask;
   endfunction

   state_e state_q, state_d;

   // holding registers
   logic                    aw_full_q, w_full_q, ar_full_q;
   logic                    aw_full_d, w_full_d, ar_full_d;
   logic [AxiAddrWidth-1:0] aw_addr_q, ar_addr_q;
   logic [31:0]             w_data_q;
   logic [3:0]              w_strb_q;

   // latched transaction and captured response
   logic                    is_wr_q;
   logic                    last_was_read_q;
   logic [CsrAddrWidth-1:0] cpu_addr_q;
   logic [31:0]             cpu_wdata_q, cpu_biten_q;
   logic                    bresp_err_q, rresp_err_q;
   logic [31:0]             rdata_q;

   // FSM strobes
   logic                    wr_elig, rd_elig;
   logic                    grant_rd, grant_wr;
   logic                    capture, time_out;
   logic                    ack_now, stall_now;
   logic [AxiAddrWidth-1:0] sel_addr;
   logic                    win_hit;

   // protection bits carry no meaning for the CSR block
   logic unused_prot;
   assign unused_prot = ^{awprot_i, arprot_i};

`ifdef I3C_AXI_LITE_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles);
   logic [CntW-1:0] to_cnt_q;

   // WAIT_ACK dwell counter; held at zero elsewhere so every entry starts from zero
   always_ff @(posedge clk_i) begin
      if (rst_i)                   to_cnt_q <= '0;
      else if (state_q != WAIT_ACK) to_cnt_q <= '0;
      else                         to_cnt_q <= to_cnt_q + 1'b1;
   end
`endif

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // arbitration, decode and next-state logic
   always_comb begin
      state_d   = state_q;
      grant_rd  = 1'b0;
      grant_wr  = 1'b0;
      capture   = 1'b0;
      time_out  = 1'b0;
      wr_elig   = aw_full_q & w_full_q;
      rd_elig   = ar_full_q;
      ack_now   = is_wr_q ? s_cpuif_wr_ack : s_cpuif_rd_ack;
      stall_now = is_wr_q ? s_cpuif_req_stall_wr : s_cpuif_req_stall_rd;
      if (state_q == IDLE) begin
         if (rd_elig && (!wr_elig || !last_was_read_q)) grant_rd = 1'b1;
         else if (wr_elig)                              grant_wr = 1'b1;
      end
      sel_addr = grant_rd ? ar_addr_q : aw_addr_q;
      win_hit  = in_window(sel_addr);
      unique case (state_q)
         IDLE: begin
            if (grant_rd || grant_wr) state_d = win_hit ? REQ : RESP;
         end
         REQ: begin
            if (ack_now) begin
               capture = 1'b1;
               state_d = RESP;
            end else if (!stall_now) begin
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ack_now) begin
               capture = 1'b1;
               state_d = RESP;
            end
`ifdef I3C_AXI_LITE_TIMEOUT_EN
            else if (to_cnt_q == CntW'(TimeoutCycles - 1)) begin
               time_out = 1'b1;
               state_d  = RESP;
            end
`endif
         end
         RESP: begin
            if (is_wr_q ? bready_i : rready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // a holding register is refilled only when empty and freed when its transaction is granted
   assign aw_full_d = (awvalid_i & awready_o) | (aw_full_q & ~grant_wr);
   assign w_full_d  = (wvalid_i  & wready_o)  | (w_full_q  & ~grant_wr);
   assign ar_full_d = (arvalid_i & arready_o) | (ar_full_q & ~grant_rd);

   // AW/W/AR holding registers with registered ready = next-cycle empty
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         ar_full_q <= 1'b0;
         aw_addr_q <= '0;
         ar_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         awready_o <= 1'b0;
         wready_o  <= 1'b0;
         arready_o <= 1'b0;
      end else begin
         aw_full_q <= aw_full_d;
         w_full_q  <= w_full_d;
         ar_full_q <= ar_full_d;
         if (awvalid_i && awready_o) aw_addr_q <= awaddr_i;
         if (arvalid_i && arready_o) ar_addr_q <= araddr_i;
         if (wvalid_i && wready_o) begin
            w_data_q <= wdata_i;
            w_strb_q <= wstrb_i;
         end
         awready_o <= ~aw_full_d;
         wready_o  <= ~w_full_d;
         arready_o <= ~ar_full_d;
      end
   end

   // grant latch, fairness flag and response capture
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         is_wr_q         <= 1'b0;
         last_was_read_q <= 1'b0;
         cpu_addr_q      <= '0;
         cpu_wdata_q     <= '0;
         cpu_biten_q     <= '0;
         bresp_err_q     <= 1'b0;
         rresp_err_q     <= 1'b0;
         rdata_q         <= '0;
      end else begin
         // the flag records the winner of the last contested arbitration only
         if (grant_rd && wr_elig)      last_was_read_q <= 1'b1;
         else if (grant_wr && rd_elig) last_was_read_q <= 1'b0;
         if (grant_rd || grant_wr) begin
            is_wr_q <= grant_wr;
            if (win_hit) begin
               cpu_addr_q  <= window_offset(sel_addr);
               cpu_wdata_q <= grant_wr ? w_data_q : '0;
               cpu_biten_q <= grant_wr ? expand_strb(w_strb_q) : '0;
            end else if (grant_wr) begin
               bresp_err_q <= 1'b1;
            end else begin
               rresp_err_q <= 1'b1;
               rdata_q     <= '0;
            end
         end
         if (capture) begin
            if (is_wr_q) begin
               bresp_err_q <= s_cpuif_wr_err;
            end else begin
               rresp_err_q <= s_cpuif_rd_err;
               rdata_q     <= s_cpuif_rd_data;
            end
         end
         if (time_out) begin
            if (is_wr_q) begin
               bresp_err_q <= 1'b1;
            end else begin
               rresp_err_q <= 1'b1;
               rdata_q     <= '0;
            end
         end
      end
   end

   assign s_cpuif_req       = (state_q == REQ);
   assign s_cpuif_req_is_wr = is_wr_q;
   assign s_cpuif_addr      = cpu_addr_q;
   assign s_cpuif_wr_data   = cpu_wdata_q;
   assign s_cpuif_wr_biten  = cpu_biten_q;
   assign bvalid_o          = (state_q == RESP) &  is_wr_q;
   assign rvalid_o          = (state_q == RESP) & ~is_wr_q;
   assign bresp_o           = {bresp_err_q, 1'b0};
   assign rresp_o           = {rresp_err_q, 1'b0};
   assign rdata_o           = rdata_q;

endmodule

// File: tb/tb_axi_lite_csr_bridge.sv
// Directed testbench for axi_lite_csr_bridge (window 0x1000..0x1FFF, CSR width 12).
// Build with I3C_AXI_LITE_TIMEOUT_EN defined to also exercise the ack timeout.

module tb_axi_lite_csr_bridge;
   localparam int unsigned AW   = 32;
   localparam int unsigned CW   = 12;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic          req, req_is_wr, stall_wr, stall_rd, rd_ack, rd_err, wr_ack, wr_err;
   logic [CW-1:0] csr_addr;
   logic [31:0]   csr_wdata, csr_biten, csr_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   axi_lite_csr_bridge #(
      .AxiAddrWidth(AW), .CsrAddrWidth(CW), .BaseAddr(BASE),
      .WindowBytes(64'h1000), .TimeoutCycles(16)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr), .awprot_i(awprot),
      .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
      .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
      .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arprot_i(arprot),
      .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
      .s_cpuif_req(req), .s_cpuif_req_is_wr(req_is_wr), .s_cpuif_addr(csr_addr),
      .s_cpuif_wr_data(csr_wdata), .s_cpuif_wr_biten(csr_biten),
      .s_cpuif_req_stall_wr(stall_wr), .s_cpuif_req_stall_rd(stall_rd),
      .s_cpuif_rd_ack(rd_ack), .s_cpuif_rd_err(rd_err), .s_cpuif_rd_data(csr_rdata),
      .s_cpuif_wr_ack(wr_ack), .s_cpuif_wr_err(wr_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      awvalid = 0; awaddr = '0; awprot = 3'b010; wvalid = 0; wdata = '0; wstrb = '0;
      arvalid = 0; araddr = '0; arprot = 3'b001; bready = 1; rready = 1;
      stall_wr = 0; stall_rd = 0; rd_ack = 0; rd_err = 0; wr_ack = 0; wr_err = 0;
      csr_rdata = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_i = 1; step(); step();
      rst_i = 0; step();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_i = 1; step(); step();
      n_checks++; if ({awready, wready, arready} !== 3'b000) begin n_fail++; $display("FAIL reset_readies: got %b expected 000", {awready, wready, arready}); end
      n_checks++; if ({bvalid, rvalid, req} !== 3'b000) begin n_fail++; $display("FAIL reset_valids: got %b expected 000", {bvalid, rvalid, req}); end
      n_checks++; if ({bresp, rresp} !== 4'b0000 || rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp: got %b/%h expected 0000/0", {bresp, rresp}, rdata); end
      n_checks++; if (csr_addr !== '0 || csr_wdata !== '0 || csr_biten !== '0) begin n_fail++; $display("FAIL reset_cpuif: got %h %h %h expected zeros", csr_addr, csr_wdata, csr_biten); end
      rst_i = 0; step();
      n_checks++; if ({awready, wready, arready} !== 3'b111) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 111", {awready, wready, arready}); end
   endtask

   task automatic test_write_basic();
      wr_ack = 1; wr_err = 0; bready = 1;
      awvalid = 1; awaddr = BASE + 32'h10; wvalid = 1; wdata = 32'hA5A5_0001; wstrb = 4'b0011;
      step();
      awvalid = 0; wvalid = 0;
      n_checks++; if (req !== 1'b0 || awready !== 1'b0) begin n_fail++; $display("FAIL wr_hold: req=%b awready=%b expected 0 0", req, awready); end
      step();
      n_checks++; if (req !== 1'b1 || req_is_wr !== 1'b1) begin n_fail++; $display("FAIL wr_req_timing: req=%b is_wr=%b expected 1 1", req, req_is_wr); end
      n_checks++; if (csr_addr !== 12'h010) begin n_fail++; $display("FAIL wr_addr: got %h expected 010", csr_addr); end
      n_checks++; if (csr_biten !== 32'h0000_FFFF || csr_wdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL wr_data_biten: got %h %h expected a5a50001 0000ffff", csr_wdata, csr_biten); end
      step();
      n_checks++; if (bvalid !== 1'b1 || bresp !== 2'b00 || req !== 1'b0) begin n_fail++; $display("FAIL wr_bvalid: bvalid=%b bresp=%b req=%b expected 1 00 0", bvalid, bresp, req); end
      step();
      n_checks++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL wr_b_done: bvalid=%b expected 0", bvalid); end
      wr_ack = 0;
   endtask

   task automatic test_read_stall();
      int req_cycles;
      req_cycles = 0;
      stall_rd = 1; rd_ack = 0; rready = 1;
      arvalid = 1; araddr = BASE + 32'h24;
      step();
      arvalid = 0;
      step(); if (req) req_cycles++;
      n_checks++; if (csr_addr !== 12'h024 || req_is_wr !== 1'b0) begin n_fail++; $display("FAIL rd_addr: got %h is_wr=%b expected 024 0", csr_addr, req_is_wr); end
      step(); if (req) req_cycles++;
      step(); if (req) req_cycles++;
      stall_rd = 0;
      step(); if (req) req_cycles++;
      step(); if (req) req_cycles++;
      rd_ack = 1; csr_rdata = 32'h1234_5678;
      step();
      rd_ack = 0; csr_rdata = 32'hFFFF_0000;
      n_checks++; if (req_cycles !== 3) begin n_fail++; $display("FAIL rd_req_pulse: got %0d cycles expected 3", req_cycles); end
      n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || rresp !== 2'b00) begin n_fail++; $display("FAIL rd_resp: rvalid=%b rdata=%h rresp=%b expected 1 12345678 00", rvalid, rdata, rresp); end
      step();
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_done: rvalid=%b expected 0", rvalid); end
   endtask

   task automatic test_arbitration();
      apply_reset();
      rd_ack = 1; wr_ack = 1; csr_rdata = 32'hCAFE_0001;
      for (int round = 0; round < 2; round++) begin
         awvalid = 1; awaddr = BASE + 32'h100 + 32'(4*round); wvalid = 1; wdata = 32'h0BAD_0000; wstrb = 4'hF;
         arvalid = 1; araddr = BASE + 32'h200 + 32'(4*round);
         step();
         awvalid = 0; wvalid = 0; arvalid = 0;
         step();
         if (round == 0) begin
            n_checks++; if (req !== 1'b1 || req_is_wr !== 1'b0 || csr_addr !== 12'h200) begin n_fail++; $display("FAIL arb_tie1_first: req=%b is_wr=%b addr=%h expected 1 0 200", req, req_is_wr, csr_addr); end
         end else begin
            n_checks++; if (req !== 1'b1 || req_is_wr !== 1'b1 || csr_addr !== 12'h104) begin n_fail++; $display("FAIL arb_tie2_first: req=%b is_wr=%b addr=%h expected 1 1 104", req, req_is_wr, csr_addr); end
         end
         step(); step(); step();
         if (round == 0) begin
            n_checks++; if (req !== 1'b1 || req_is_wr !== 1'b1 || csr_addr !== 12'h100) begin n_fail++; $display("FAIL arb_tie1_second: req=%b is_wr=%b addr=%h expected 1 1 100", req, req_is_wr, csr_addr); end
         end else begin
            n_checks++; if (req !== 1'b1 || req_is_wr !== 1'b0 || csr_addr !== 12'h204) begin n_fail++; $display("FAIL arb_tie2_second: req=%b is_wr=%b addr=%h expected 1 0 204", req, req_is_wr, csr_addr); end
         end
         step(); step();
      end
      rd_ack = 0; wr_ack = 0;
   endtask

   task automatic test_out_of_range();
      logic [31:0] addrs [2];
      logic saw_req, got;
      addrs[0] = BASE + 32'h1000;
      addrs[1] = BASE - 32'h4;
      for (int k = 0; k < 2; k++) begin
         rd_ack = 1; csr_rdata = 32'hDEAD_BEEF; rready = 0; saw_req = 0; got = 0;
         arvalid = 1; araddr = addrs[k];
         step();
         arvalid = 0;
         for (int i = 0; i < 6; i++) begin
            step();
            if (req) saw_req = 1;
            if (rvalid) begin got = 1; break; end
         end
         n_checks++; if (got !== 1'b1 || saw_req !== 1'b0) begin n_fail++; $display("FAIL oor_flow[%0d]: rvalid_seen=%b req_seen=%b expected 1 0", k, got, saw_req); end
         n_checks++; if (rresp !== 2'b10 || rdata !== 32'h0) begin n_fail++; $display("FAIL oor_resp[%0d]: rresp=%b rdata=%h expected 10 0", k, rresp, rdata); end
         rready = 1;
         step();
         rd_ack = 0;
         // a good read restores non-zero rdata so the next zero check is meaningful
         rd_ack = 1; csr_rdata = 32'h0A0B_0C0D; arvalid = 1; araddr = BASE + 32'h8;
         step(); arvalid = 0; step(); step(); step();
         rd_ack = 0;
      end
   endtask

   task automatic test_back_to_back();
      bready = 0; wr_ack = 1; wr_err = 1;
      awvalid = 1; awaddr = BASE + 32'h40; wvalid = 1; wdata = 32'h1111_2222; wstrb = 4'hF;
      step();
      awvalid = 0; wvalid = 0;
      step(); step();
      wr_err = 0;
      n_checks++; if (awready !== 1'b1 || wready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: aw=%b w=%b expected 1 1", awready, wready); end
      awvalid = 1; awaddr = BASE + 32'h47; wvalid = 1; wdata = 32'h3333_4444; wstrb = 4'b1100;
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (bvalid !== 1'b1 || bresp !== 2'b10 || req !== 1'b0) begin n_fail++; $display("FAIL b2b_stable[%0d]: bvalid=%b bresp=%b req=%b expected 1 10 0", i, bvalid, bresp, req); end
         step();
         awvalid = 0; wvalid = 0;
      end
      n_checks++; if (awready !== 1'b0 || bvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_held: awready=%b bvalid=%b expected 0 1", awready, bvalid); end
      bready = 1;
      step();
      n_checks++; if (bvalid !== 1'b0 || req !== 1'b0) begin n_fail++; $display("FAIL b2b_bdone: bvalid=%b req=%b expected 0 0", bvalid, req); end
      step();
      n_checks++; if (req !== 1'b1 || csr_addr !== 12'h044 || csr_biten !== 32'hFFFF_0000 || csr_wdata !== 32'h3333_4444) begin n_fail++; $display("FAIL b2b_second: req=%b addr=%h biten=%h data=%h expected 1 044 ffff0000 33334444", req, csr_addr, csr_biten, csr_wdata); end
      step();
      n_checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin n_fail++; $display("FAIL b2b_second_resp: bvalid=%b bresp=%b expected 1 00", bvalid, bresp); end
      step();
      wr_ack = 0;
   endtask

`ifdef I3C_AXI_LITE_TIMEOUT_EN
   task automatic test_timeout();
      int cnt;
      cnt = 0; rd_ack = 0; stall_rd = 0; rready = 1;
      arvalid = 1; araddr = BASE + 32'h30;
      step();
      arvalid = 0;
      step(); step();
      while (!rvalid && cnt < 40) begin step(); cnt++; end
      n_checks++; if (cnt !== 16) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected 16", cnt); end
      n_checks++; if (rresp !== 2'b10 || rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_resp: rresp=%b rdata=%h expected 10 0", rresp, rdata); end
      step();
   endtask
`endif

   task automatic test_reset_mid();
      logic saw;
      saw = 0; rd_ack = 0; stall_rd = 0; rready = 1;
      arvalid = 1; araddr = BASE + 32'h80;
      step();
      arvalid = 0;
      step(); step(); step();
      n_checks++; if (req !== 1'b0 || rvalid !== 1'b0 || csr_addr !== 12'h080) begin n_fail++; $display("FAIL mid_wait: req=%b rvalid=%b addr=%h expected 0 0 080", req, rvalid, csr_addr); end
      arvalid = 1; araddr = BASE + 32'h84;
      step();
      arvalid = 0;
      rst_i = 1;
      step();
      n_checks++; if ({awready, wready, arready, bvalid, rvalid, req} !== 6'b0) begin n_fail++; $display("FAIL mid_reset_ctrl: got %b expected 000000", {awready, wready, arready, bvalid, rvalid, req}); end
      n_checks++; if (csr_addr !== '0 || csr_wdata !== '0 || rdata !== '0 || {bresp, rresp} !== 4'b0) begin n_fail++; $display("FAIL mid_reset_data: addr=%h wdata=%h rdata=%h resp=%b expected zeros", csr_addr, csr_wdata, rdata, {bresp, rresp}); end
      rst_i = 0; rd_ack = 1; csr_rdata = 32'h5555_AAAA;
      for (int i = 0; i < 12; i++) begin
         step();
         if (rvalid || bvalid || req) saw = 1;
      end
      n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL mid_no_response: activity=%b expected 0", saw); end
      rd_ack = 0;
   endtask

   initial begin
      rst_i = 1;
      idle_inputs();
      test_reset();
      test_write_basic();
      test_read_stall();
      test_arbitration();
      test_out_of_range();
      test_back_to_back();
`ifdef I3C_AXI_LITE_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
